// File: rtl/pc_ctrl_defs.sv
// Shared definitions for the PC button front end: button indices, command
// op codes, sequencer FSM states and the request priority helpers.
package pc_ctrl_defs;

    localparam int NUM_BTNS = 5;

    // Button positions in the packed button vectors.
    localparam logic [2:0] BTN_S = 3'd0;
    localparam logic [2:0] BTN_U = 3'd1;
    localparam logic [2:0] BTN_D = 3'd2;
    localparam logic [2:0] BTN_R = 3'd3;
    localparam logic [2:0] BTN_L = 3'd4;

    // Buttons that request a command (btns is only the master enable).
    localparam logic [NUM_BTNS-1:0] REQ_MASK = 5'b11110;

    // Command op codes presented to the PC datapath.
    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_INC     = 3'b001;
    localparam logic [2:0] OP_DEC     = 3'b010;
    localparam logic [2:0] OP_LOAD    = 3'b011;
    localparam logic [2:0] OP_ADD_REL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Highest-priority pending request: R > L > U > D. BTN_S means none.
    function automatic logic [2:0] pick_button(input logic [NUM_BTNS-1:0] pending);
        if ((pending & REQ_MASK) == '0) return BTN_S;
        else if (pending[BTN_R])        return BTN_R;
        else if (pending[BTN_L])        return BTN_L;
        else if (pending[BTN_U])        return BTN_U;
        else                            return BTN_D;
    endfunction

    function automatic logic [2:0] op_for_button(input logic [2:0] btn);
        case (btn)
            BTN_R:   return OP_LOAD;
            BTN_L:   return OP_ADD_REL;
            BTN_U:   return OP_INC;
            BTN_D:   return OP_DEC;
            default: return OP_NOP;
        endcase
    endfunction

    // Only LOAD and ADD_REL carry new_count as operand.
    function automatic logic button_has_operand(input logic [2:0] btn);
        return (btn == BTN_R) || (btn == BTN_L);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: two-flop synchronizer, stability counter and a one-cycle
// pulse on each rising edge of the debounced level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] count_reg;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Flip the level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            rise_reg <= 1'b0;
            if (sync2_reg != level_reg) begin
                if (count_reg == CNT_LAST) begin
                    level_reg <= sync2_reg;
                    rise_reg  <= sync2_reg;
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end else begin
                count_reg <= '0;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/pc_button_sequencer.sv
// Front-end controller for the program counter: debounces the five board
// buttons, queues presses as pending requests and hands one command at a
// time to the PC datapath over a valid/ready handshake.
module pc_button_sequencer
    import pc_ctrl_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PC_WIDTH        = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                btns,
    input  logic                btnu,
    input  logic                btnd,
    input  logic                btnr,
    input  logic                btnl,
    input  logic [PC_WIDTH-1:0] new_count,
    input  logic                pc_ready,
    output logic                cmd_valid,
    output logic [2:0]          cmd_op,
    output logic [PC_WIDTH-1:0] cmd_operand,
    output logic [7:0]          cmd_count,
    output logic                busy
);

    localparam logic [NUM_BTNS-1:0] ONE_HOT_0 = NUM_BTNS'(1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_rise;

    logic [NUM_BTNS-1:0] pending_reg;
    logic [NUM_BTNS-1:0] pending_eff;
    logic [NUM_BTNS-1:0] pending_next;
    logic                pending_any;
    logic [2:0]          sel_idx;

    state_t              state_reg;
    logic [2:0]          issued_reg;
    logic                cmd_valid_reg;
    logic [2:0]          cmd_op_reg;
    logic [PC_WIDTH-1:0] cmd_operand_reg;
    logic [7:0]          cmd_count_reg;
    logic                busy_reg;

    assign btn_raw = {btnl, btnr, btnd, btnu, btns};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock(clock),
                .reset(reset),
                .raw  (btn_raw[gi]),
                .level(btn_level[gi]),
                .rise (btn_rise[gi])
            );
        end
    endgenerate

    // Pending requests are only honoured, and only collected, while the master enable is on.
    always_comb begin
        pending_eff  = btn_level[BTN_S] ? pending_reg : '0;
        pending_next = pending_eff | (btn_rise & REQ_MASK & {NUM_BTNS{btn_level[BTN_S]}});
        pending_any  = (pending_eff & REQ_MASK) != '0;
        sel_idx      = pick_button(pending_eff);
    end

    // Sequencer: select a request, hold it on the handshake, then wait for its button to be let go.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            pending_reg     <= '0;
            issued_reg      <= BTN_S;
            cmd_valid_reg   <= 1'b0;
            cmd_op_reg      <= OP_NOP;
            cmd_operand_reg <= '0;
            cmd_count_reg   <= 8'd0;
            busy_reg        <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            case (state_reg)
                S_IDLE: begin
                    if (pending_any) begin
                        pending_reg     <= pending_next & ~(ONE_HOT_0 << sel_idx);
                        issued_reg      <= sel_idx;
                        cmd_op_reg      <= op_for_button(sel_idx);
                        cmd_operand_reg <= button_has_operand(sel_idx) ? new_count : '0;
                        cmd_valid_reg   <= 1'b1;
                        busy_reg        <= 1'b1;
                        state_reg       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pc_ready) begin
                        cmd_valid_reg <= 1'b0;
                        cmd_count_reg <= cmd_count_reg + 8'd1;
                        state_reg     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // A held button must not retrigger; other pending requests wait here.
                    if (!btn_level[issued_reg]) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    cmd_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid   = cmd_valid_reg;
    assign cmd_op      = cmd_op_reg;
    assign cmd_operand = cmd_operand_reg;
    assign cmd_count   = cmd_count_reg;
    assign busy        = busy_reg;

endmodule
